// File: rtl/iecdrv_sd_pkg.sv
// Shared types and helpers for the drive-internal SD block arbiter.
package iecdrv_sd_pkg;

    localparam int unsigned SD_LBA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        XFER,
        DRAIN
    } sd_arb_state_t;

    // Requester index: 0 = GCR track loader, 1 = fdc1772 MFM controller.
    typedef logic sd_req_idx_t;

    // With both pending the favoured requester wins; otherwise the lone pending one.
    function automatic sd_req_idx_t rr_pick(input logic [1:0] pend, input sd_req_idx_t prio);
        return (pend == 2'b11) ? prio : sd_req_idx_t'(pend[1]);
    endfunction

endpackage

// File: rtl/iecdrv_sd_arbiter.sv
// Two-way round-robin arbiter in front of the MiSTer SD block interface.
// One sector transfer is sequenced at a time; a missing sd_ack aborts after ACK_TIMEOUT cycles.
module iecdrv_sd_arbiter
    import iecdrv_sd_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 1048576,
    parameter int unsigned TMO_W       = 21
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [SD_LBA_W-1:0] r0_lba,
    input  logic                r0_rd,
    input  logic                r0_wr,
    output logic                r0_ack,
    output logic                r0_buff_wr,
    input  logic [7:0]          r0_buff_din,
    output logic                r0_err,

    input  logic [SD_LBA_W-1:0] r1_lba,
    input  logic                r1_rd,
    input  logic                r1_wr,
    output logic                r1_ack,
    output logic                r1_buff_wr,
    input  logic [7:0]          r1_buff_din,
    output logic                r1_err,

    output logic [SD_LBA_W-1:0] sd_lba,
    output logic                sd_rd,
    output logic                sd_wr,
    input  logic                sd_ack,
    input  logic                sd_buff_wr,
    output logic [7:0]          sd_buff_din,

    output logic [1:0]          grant,
    output logic                busy
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    sd_arb_state_t       state_q, state_d;
    logic [SD_LBA_W-1:0] lba_q, lba_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [1:0]          grant_q, grant_d;
    logic                busy_q, busy_d;
    logic [1:0]          err_q, err_d;
    sd_req_idx_t         prio_q, prio_d;
    sd_req_idx_t         owner_q, owner_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;

    logic [1:0]          pend;
    sd_req_idx_t         pick;
    logic                active;

    assign pend = {r1_rd | r1_wr, r0_rd | r0_wr};
    assign pick = rr_pick(pend, prio_q);

    // State and registered outputs; synchronous reset back to idle, favouring r0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lba_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
            err_q   <= 2'b00;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            lba_q   <= lba_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        lba_d   = lba_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        grant_d = grant_q;
        err_d   = 2'b00;
        prio_d  = prio_q;
        owner_d = owner_q;
        tmo_d   = tmo_q;

        unique case (state_q)
            IDLE: begin
                // A stale ack (after reset or abort) must clear before anyone is granted.
                if (!sd_ack && (pend != 2'b00)) begin
                    owner_d = pick;
                    lba_d   = pick ? r1_lba : r0_lba;
                    // Read wins when a requester raises both rd and wr.
                    rd_d    = pick ? r1_rd : r0_rd;
                    wr_d    = pick ? (r1_wr & ~r1_rd) : (r0_wr & ~r0_rd);
                    grant_d = pick ? 2'b10 : 2'b01;
                    tmo_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Latched lba/op govern here; requester rd/wr are no longer looked at.
                tmo_d = tmo_q + 1'b1;
                if (sd_ack) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    tmo_d   = '0;
                    state_d = XFER;
                end else if (tmo_q == TMO_LAST) begin
                    rd_d           = 1'b0;
                    wr_d           = 1'b0;
                    tmo_d          = '0;
                    err_d[owner_q] = 1'b1;
                    prio_d         = ~owner_q;
                    state_d        = DRAIN;
                end
            end
            XFER: begin
                if (!sd_ack) begin
                    prio_d  = ~owner_q;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // One dead cycle lets the served requester drop rd/wr before re-sampling.
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: begin
                grant_d = 2'b00;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Combinational routing of ack, buffer strobes and write data to the owner only.
    always_comb begin
        active      = (state_q == ISSUE) || (state_q == XFER);
        r0_ack      = sd_ack & grant_q[0] & active;
        r1_ack      = sd_ack & grant_q[1] & active;
        r0_buff_wr  = sd_buff_wr & sd_ack & grant_q[0] & active;
        r1_buff_wr  = sd_buff_wr & sd_ack & grant_q[1] & active;
        sd_buff_din = 8'h00;
        if (grant_q[0]) begin
            sd_buff_din = r0_buff_din;
        end else if (grant_q[1]) begin
            sd_buff_din = r1_buff_din;
        end
    end

    assign sd_lba = lba_q;
    assign sd_rd  = rd_q;
    assign sd_wr  = wr_q;
    assign grant  = grant_q;
    assign busy   = busy_q;
    assign r0_err = err_q[0];
    assign r1_err = err_q[1];

endmodule
